led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Ping-pong frame-buffer controller for the LED output path. It owns one internal `bram` instance that holds two frames.
- A host byte stream fills the back buffer. NUM_CHANNELS strip drivers share the single read port through a round-robin arbiter; each driver streams its own slice of the front buffer.
- The front and back buffers swap only at a frame boundary. If no new frame is ready, the current front frame is replayed.

Parameters:
- NUM_CHANNELS, 4, number of strip-driver requesters.
- CHANNEL_BYTES, 32, bytes per channel per frame.
- DATA_WIDTH, 8, byte width (passed to `bram`).
- FRAME_BYTES, NUM_CHANNELS*CHANNEL_BYTES (derived), bytes per frame.
- ADDRESS_WIDTH, $clog2(2*FRAME_BYTES) (derived), `bram` address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- host_valid  in  1  host byte valid.
- host_ready  out  1  host byte accepted when host_valid && host_ready.
- host_data  in  DATA_WIDTH  pixel byte.
- host_last  in  1  marks the final byte of a frame.
- ch_req  in  NUM_CHANNELS  level per channel: "want next byte".
- ch_valid  out  NUM_CHANNELS  one-hot, 1-cycle, data-return strobe.
- ch_data  out  DATA_WIDTH  shared return data, qualified by ch_valid.
- ch_last  out  1  returned byte is the channel's final byte of the frame.
- frame_start  out  1  1-cycle pulse when a new frame pass begins.
- front_sel  out  1  buffer currently being displayed (0: addresses 0..FRAME_BYTES-1; 1: upper half).
- overflow  out  1  sticky flag: host exceeded FRAME_BYTES without host_last.

Behaviour:
- Reset (sync, highest priority):
  - state=EMPTY, front_sel=0, wr_ptr=0, back_complete=0, overflow=0.
  - All channel counters, pending and done bits cleared.
  - Outputs: ch_valid=0, ch_last=0, frame_start=0.
  - Any read in flight when rst is asserted produces no ch_valid.
  - bram contents are not cleared.
- Host write side:
  - host_ready=1 except in state SWAP, or when back_complete=1.
  - On accept: wen=1, waddr=(~front_sel)*FRAME_BYTES+wr_ptr, then wr_ptr++.
  - Accept with host_last: back_complete=1. A short frame leaves the untouched tail bytes with stale content.
  - Accept with wr_ptr==FRAME_BYTES and no host_last: byte dropped (wen=0), overflow set.
- Read arbitration (states STREAM/DRAIN):
  - A channel is eligible when ch_req[c] && !pending[c] && !done[c].
  - The round-robin arbiter grants at most one channel per cycle; the pointer advances to one past the winner.
  - Grant to g in cycle N:
    - ren=1, raddr = front_sel*FRAME_BYTES + g*CHANNEL_BYTES + cnt[g].
    - cnt[g]++, pending[g]=1.
    - If cnt[g] was CHANNEL_BYTES-1, done[g]=1.
  - Cycle N+1: ch_valid[g]=1, ch_data=rdata, ch_last=1 if that byte was the channel's last; pending[g]=0.
  - Throughput: read latency is 1 cycle. Aggregate rate is 1 byte/cycle; each channel gets at most 1 byte per 2 cycles. ch_req may stay high continuously.
  - Write and read can occur in the same cycle; they always target different halves.
- State machine:
  - EMPTY: no grants. Exit to SWAP once back_complete=1.
  - STREAM: grants as above. Exit to DRAIN when all done bits are set.
  - DRAIN: no grants. Exit to SWAP once no read is pending (the last ch_valid has issued).
  - SWAP, 1 cycle:
    - If back_complete: toggle front_sel, clear back_complete, clear wr_ptr.
    - Always clear cnt, done and pending.
    - Next state STREAM; frame_start=1 in the first STREAM cycle.
- Ordering: host_last accepted during DRAIN takes effect at the immediately following SWAP. There is no frame tearing, because a swap never happens mid-pass.
- Channel done early: a channel with done[c]=1 gets no further grants until the next frame_start, even if ch_req stays high.

Decomposition:
- Shared package `ledsuit_pkg`:
  - state encoding (EMPTY, STREAM, DRAIN, SWAP).
  - default NUM_CHANNELS, CHANNEL_BYTES and DATA_WIDTH constants.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: req vector, advance.
  - outputs: one-hot grant, grant index.
  - the rotating pointer resets to 0.
- Memory: the existing `bram` module, instantiated with MEMORY_SIZE=2*FRAME_BYTES.

Test Plan:
1. Reset, all ch_req=1, no host data for 20 cycles → ch_valid stays 0, state EMPTY, host_ready=1.
2. Host writes 128 bytes (value=index) with host_last on byte 127 → SWAP, front_sel=1, frame_start pulse. Channel 2 receives bytes 64..95 in order, with ch_last on 95.
3. All 4 channels request continuously → grants rotate 0,1,2,3; one ch_valid per cycle. The frame completes in ~129 cycles and replays with frame_start again, front_sel unchanged.
4. A second frame (value=0xA0+index) is written mid-pass → no change until the current pass ends. The next pass returns the new data and front_sel toggles to 0; host_ready=0 from host_last until the swap.
5. Host sends 130 bytes with no host_last → overflow=1 after byte 128; bytes 128–129 not written. A later host_last is still accepted and no swap occurs before it.
6. Assert rst the cycle after a grant → no ch_valid the next cycle; all outputs return to reset values; EMPTY state.

Source files
------------

// File: rtl/ledsuit_pkg.sv
// ---------------------------------------------------------------------------
// ledsuit_pkg
// Shared definitions for the LED frame path: the frame scheduler state
// encoding, default geometry constants and a small width helper.
// ---------------------------------------------------------------------------
package ledsuit_pkg;

  // Frame scheduler states.
  //   ST_EMPTY  : nothing displayable yet, waiting for the first full frame
  //   ST_STREAM : channels are being served from the front buffer
  //   ST_DRAIN  : every channel is done, waiting for the last read to return
  //   ST_SWAP   : one-cycle frame boundary (buffer swap / pass restart)
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWAP   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_NUM_CHANNELS  = 4;
  localparam int DEFAULT_CHANNEL_BYTES = 32;
  localparam int DEFAULT_DATA_WIDTH    = 8;

  // Width of an index into n items; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram.sv
// ---------------------------------------------------------------------------
// bram
// Simple dual-port block RAM: one synchronous write port, one synchronous
// read port with a single cycle of read latency.
//
// Ports:
//   clk    in   clock
//   wen    in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   ren    in   read enable; rdata updates on the following edge
//   raddr  in   read address
//   rdata  out  registered read data (holds when ren=0)
// ---------------------------------------------------------------------------
module bram #(
  parameter int MEMORY_SIZE   = 256,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_SIZE)
) (
  input  logic                     clk,
  input  logic                     wen,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     ren,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];

  // NOTE: the storage array has no reset on purpose; resetting a RAM array
  // turns it into flops and frame contents are allowed to survive a reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at a rotating pointer; after a
// granted cycle with advance=1 the pointer moves to one past the winner, so
// the most recent winner has lowest priority next time.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (pointer -> 0)
//   req        in   request vector
//   advance    in   commit this cycle's grant (move the pointer)
//   grant      out  one-hot grant (all zero when no request)
//   grant_idx  out  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import ledsuit_pkg::*;
#(
  parameter  int N  = DEFAULT_NUM_CHANNELS,
  localparam int IW = index_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
// Ping-pong frame buffer controller for the LED output path. One bram holds
// two frames: the host fills the back half while the strip drivers stream
// their slices of the front half through a shared, round-robin arbitrated
// read port. Halves swap only between passes; with no new frame ready the
// front frame is replayed.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   host_valid   in   host byte valid
//   host_ready   out  host byte accepted when host_valid && host_ready
//   host_data    in   pixel byte
//   host_last    in   final byte of a host frame
//   ch_req       in   per-channel "want next byte" level
//   ch_valid     out  one-hot single-cycle data return strobe
//   ch_data      out  shared return data, qualified by ch_valid
//   ch_last      out  returned byte is the channel's last of the frame
//   frame_start  out  single-cycle pulse in the first cycle of a pass
//   front_sel    out  half currently displayed (0: low, 1: high)
//   overflow     out  sticky: host sent more than a frame without host_last
// ---------------------------------------------------------------------------
module led_frame_scheduler
  import ledsuit_pkg::*;
#(
  parameter  int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter  int CHANNEL_BYTES = DEFAULT_CHANNEL_BYTES,
  parameter  int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  localparam int FRAME_BYTES   = NUM_CHANNELS * CHANNEL_BYTES,
  localparam int ADDRESS_WIDTH = $clog2(2 * FRAME_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [DATA_WIDTH-1:0]   host_data,
  input  logic                    host_last,
  input  logic [NUM_CHANNELS-1:0] ch_req,
  output logic [NUM_CHANNELS-1:0] ch_valid,
  output logic [DATA_WIDTH-1:0]   ch_data,
  output logic                    ch_last,
  output logic                    frame_start,
  output logic                    front_sel,
  output logic                    overflow
);

  localparam int CH_W  = index_width(NUM_CHANNELS);
  localparam int CNT_W = $clog2(CHANNEL_BYTES + 1);
  localparam int PTR_W = $clog2(FRAME_BYTES + 1);

  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(CHANNEL_BYTES - 1);
  localparam logic [PTR_W-1:0]         PTR_FULL  = PTR_W'(FRAME_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] HALF_BASE = ADDRESS_WIDTH'(FRAME_BYTES);

  sched_state_t state;

  // Host side
  logic [PTR_W-1:0] wr_ptr;
  logic             back_complete;
  logic             host_accept;
  logic             host_room;

  // Read side
  logic [CNT_W-1:0]        cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] done;
  logic [NUM_CHANNELS-1:0] arb_req;
  logic [NUM_CHANNELS-1:0] grant;
  logic [CH_W-1:0]         grant_idx;
  logic                    granted;
  logic [CNT_W-1:0]        grant_cnt;
  logic                    grant_is_last;

  // BRAM ports
  logic                     wen;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic                     ren;
  logic [ADDRESS_WIDTH-1:0] raddr;

  // ------------------------------------------------------------------------
  // Host write path. Bytes always land in the half that is not displayed.
  // Once the write pointer reaches the end of the half, further bytes are
  // swallowed (not written) so they can never wrap into the front frame.
  // ------------------------------------------------------------------------
  assign host_ready  = (state != ST_SWAP) && !back_complete;
  assign host_accept = host_valid && host_ready;
  assign host_room   = (wr_ptr != PTR_FULL);
  assign wen         = host_accept && host_room && !rst;
  assign waddr       = (front_sel ? '0 : HALF_BASE) + ADDRESS_WIDTH'(wr_ptr);

  // ------------------------------------------------------------------------
  // Read arbitration. A channel with a read in flight is held off for one
  // cycle, which caps each channel at one byte every two cycles while the
  // port as a whole can still return a byte every cycle.
  // ------------------------------------------------------------------------
  assign arb_req = (state == ST_STREAM) ? (ch_req & ~pending & ~done) : '0;

  rr_arbiter #(
    .N (NUM_CHANNELS)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (state == ST_STREAM),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign granted       = |grant;
  assign grant_cnt     = cnt[grant_idx];
  assign grant_is_last = (grant_cnt == CNT_LAST);

  assign ren   = granted;
  assign raddr = (front_sel ? HALF_BASE : '0)
               + ADDRESS_WIDTH'(int'(grant_idx) * CHANNEL_BYTES)
               + ADDRESS_WIDTH'(grant_cnt);

  bram #(
    .MEMORY_SIZE   (2 * FRAME_BYTES),
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_bram (
    .clk   (clk),
    .wen   (wen),
    .waddr (waddr),
    .wdata (host_data),
    .ren   (ren),
    .raddr (raddr),
    .rdata (ch_data)
  );

  // ------------------------------------------------------------------------
  // Control state, counters and registered strobes.
  // ------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block (the SWAP
  // clears) deliberately override earlier ones in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EMPTY;
      front_sel     <= 1'b0;
      wr_ptr        <= '0;
      back_complete <= 1'b0;
      overflow      <= 1'b0;
      pending       <= '0;
      done          <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) cnt[c] <= '0;
      ch_valid      <= '0;
      ch_last       <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      // Data returns one cycle after the grant, together with bram rdata.
      ch_valid    <= grant;
      ch_last     <= granted && grant_is_last;
      frame_start <= (state == ST_SWAP);

      // A read is pending from its grant until its ch_valid cycle ends.
      pending <= (pending & ~ch_valid) | grant;

      if (granted) begin
        cnt[grant_idx] <= grant_cnt + 1'b1;
        if (grant_is_last) done[grant_idx] <= 1'b1;
      end

      if (host_accept) begin
        if (host_room)       wr_ptr   <= wr_ptr + 1'b1;
        else if (!host_last) overflow <= 1'b1;
        if (host_last)       back_complete <= 1'b1;
      end

      case (state)
        ST_EMPTY:  if (back_complete) state <= ST_SWAP;
        ST_STREAM: if (&done)         state <= ST_DRAIN;
        ST_DRAIN:  if (pending == '0) state <= ST_SWAP;
        ST_SWAP: begin
          // host_ready is low here, so no host update competes with these.
          if (back_complete) begin
            front_sel     <= ~front_sel;
            back_complete <= 1'b0;
            wr_ptr        <= '0;
          end
          pending <= '0;
          done    <= '0;
          for (int c = 0; c < NUM_CHANNELS; c++) cnt[c] <= '0;
          state   <= ST_STREAM;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
// Directed sequence with randomized host data, host gaps and channel
// requests. A behavioural model (two frame halves as a byte array, a
// front-half index, per-channel byte counts) predicts every returned byte.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;

  localparam int NC = 4;
  localparam int CB = 32;
  localparam int DW = 8;
  localparam int FB = NC * CB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [DW-1:0] host_data = '0;
  logic          host_last = 1'b0;
  logic [NC-1:0] ch_req = '0;
  logic [NC-1:0] ch_valid;
  logic [DW-1:0] ch_data;
  logic          ch_last;
  logic          frame_start;
  logic          front_sel;
  logic          overflow;

  always #5 clk = ~clk;

  led_frame_scheduler #(
    .NUM_CHANNELS  (NC),
    .CHANNEL_BYTES (CB),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_data   (host_data),
    .host_last   (host_last),
    .ch_req      (ch_req),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_last     (ch_last),
    .frame_start (frame_start),
    .front_sel   (front_sel),
    .overflow    (overflow)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  logic [DW-1:0] mem_m [2*FB];
  int  front_m      = 0;
  int  wr_m         = 0;
  bit  back_ready_m = 0;
  bit  ovf_m        = 0;
  bit  streaming_m  = 0;
  bit  pass_all_req = 0;
  bit  fs_prev      = 0;
  bit  prev_valid   = 0;
  int  idx_m    [NC];
  int  last_cyc [NC];
  int  total_m  = 0;
  int  prev_ch  = 0;
  int  cyc      = 0;
  int  fs_cyc   = 0;
  int  fs_count = 0;
  int  mon_c    = 0;
  bit  rand_req = 0;

  initial begin
    for (int i = 0; i < NC; i++) begin
      idx_m[i]    = 0;
      last_cyc[i] = -10;
    end
  end

  // Outputs are observed on the falling edge, half a cycle from the
  // active edge; inputs change just after the rising edge.
  always @(negedge clk) begin
    cyc++;

    if (frame_start) begin
      fs_count++;
      check("frame_start_pulse", fs_prev, 0);
      if (streaming_m) begin
        for (int i = 0; i < NC; i++) check("pass_complete", idx_m[i], CB);
        if (pass_all_req) check("pass_length", (cyc - fs_cyc) <= FB + 8, 1);
      end
      if (back_ready_m) begin
        front_m      = 1 - front_m;
        back_ready_m = 0;
        wr_m         = 0;
      end
      streaming_m  = 1;
      for (int i = 0; i < NC; i++) idx_m[i] = 0;
      total_m      = 0;
      prev_valid   = 0;
      fs_cyc       = cyc;
      pass_all_req = (ch_req == '1);
    end

    check("front_sel", front_sel, front_m);
    check("overflow", overflow, ovf_m);
    check("ch_valid_onehot", $onehot0(ch_valid), 1);

    if (pass_all_req && streaming_m && (fs_prev || (prev_valid && total_m < FB)))
      check("ch_valid_every_cycle", ch_valid != '0, 1);

    if (ch_valid != '0) begin
      for (int i = NC - 1; i >= 0; i--) if (ch_valid[i]) mon_c = i;
      check("valid_in_pass", streaming_m, 1);
      check("channel_overrun", idx_m[mon_c] < CB, 1);
      if (idx_m[mon_c] < CB) begin
        check("ch_data", ch_data, mem_m[front_m*FB + mon_c*CB + idx_m[mon_c]]);
        check("ch_last", ch_last, idx_m[mon_c] == CB - 1);
      end
      check("channel_spacing", (cyc - last_cyc[mon_c]) >= 2, 1);
      if (pass_all_req && prev_valid) check("rotation", mon_c, (prev_ch + 1) % NC);
      last_cyc[mon_c] = cyc;
      idx_m[mon_c]++;
      total_m++;
      prev_ch    = mon_c;
      prev_valid = 1;
    end else begin
      prev_valid = 0;
    end

    if (ch_req != '1) pass_all_req = 0;
    if (back_ready_m) check("host_ready_blocked", host_ready, 0);
    fs_prev = frame_start;

    if (!rst && host_valid && host_ready) begin
      if (wr_m < FB) begin
        mem_m[(1 - front_m)*FB + wr_m] = host_data;
        wr_m++;
      end else if (!host_last) begin
        ovf_m = 1;
      end
      if (host_last) back_ready_m = 1;
    end

    if (rst) begin
      front_m      = 0;
      wr_m         = 0;
      back_ready_m = 0;
      ovf_m        = 0;
      streaming_m  = 0;
      pass_all_req = 0;
      fs_prev      = 0;
      prev_valid   = 0;
      total_m      = 0;
      for (int i = 0; i < NC; i++) idx_m[i] = 0;
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_req) ch_req = 4'($urandom);
  endtask

  task automatic host_send(input logic [DW-1:0] d, input logic last);
    int  waited = 0;
    bit  rdy;
    bit  timed_out = 0;
    host_valid = 1'b1;
    host_data  = d;
    host_last  = last;
    forever begin
      @(negedge clk);
      rdy = host_ready;
      tick();
      if (rdy) break;
      waited++;
      if (waited > 2000) begin
        timed_out = 1;
        break;
      end
    end
    check("host_accept_wait", timed_out, 0);
    host_valid = 1'b0;
    host_last  = 1'b0;
    host_data  = 8'($urandom);
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic wait_fs(input int budget);
    int start = fs_count;
    int n = 0;
    while (fs_count == start && n < budget) begin
      tick();
      n++;
    end
    check("frame_start_wait", fs_count != start, 1);
  endtask

  task automatic wait_front(input logic exp, input int budget);
    int n = 0;
    while (front_sel !== exp && n < budget) begin
      tick();
      n++;
    end
    check("front_sel_wait", front_sel, exp);
  endtask

  // ------------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset with every channel requesting
    ch_req = '1;
    repeat (20) tick();
    @(negedge clk);
    check("t1_host_ready", host_ready, 1);
    check("t1_ch_valid", ch_valid, 0);
    check("t1_frame_start", frame_start, 0);
    check("t1_front_sel", front_sel, 0);

    // 2: first frame, value = index
    for (int i = 0; i < FB; i++) host_send(8'(i), i == FB - 1);
    wait_front(1'b1, 400);
    @(negedge clk);
    check("t2_front_sel", front_sel, 1);

    // 3: replay of the same frame
    wait_fs(400);
    @(negedge clk);
    check("t3_front_replay", front_sel, 1);

    // 4: second frame written mid-pass
    repeat (10) tick();
    for (int i = 0; i < FB; i++) host_send(8'(8'hA0 + i), i == FB - 1);
    wait_front(1'b0, 600);
    @(negedge clk);
    check("t4_front_sel", front_sel, 0);

    // 5: overflow (130 bytes, no host_last), random channel requests
    rand_req = 1;
    for (int i = 0; i < FB + 2; i++) host_send(8'($urandom), 1'b0);
    @(negedge clk);
    check("t5_overflow", overflow, 1);
    check("t5_host_ready", host_ready, 1);
    repeat (300) tick();
    @(negedge clk);
    check("t5_no_swap", front_sel, 0);
    host_send(8'($urandom), 1'b1);
    wait_front(1'b1, 1500);
    rand_req = 0;
    ch_req   = '1;

    // 6: reset while a read is in flight
    wait_fs(1500);
    wait_fs(400);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_ch_valid", ch_valid, 0);
    check("t6_ch_last", ch_last, 0);
    check("t6_frame_start", frame_start, 0);
    check("t6_front_sel", front_sel, 0);
    check("t6_overflow", overflow, 0);
    check("t6_host_ready", host_ready, 1);
    repeat (15) tick();
    @(negedge clk);
    check("t6_idle_ch_valid", ch_valid, 0);
    check("t6_idle_host_ready", host_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
